// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush arbiter with multi-cycle divide sequencer
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        dmem_busy,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DIV  = 1'b1;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  // The start cycle already counts as one hold cycle, so the counter holds the remainder.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      perf_q, perf_d;
  logic             in_div;
  logic             div_stall;
  logic             cnt_zero;

  always_comb begin
    in_div    = (state_q == S_DIV);
    cnt_zero  = (cnt_q == '0);
    div_stall = (!in_div && div_start) || (in_div && !cnt_zero);
  end

  // Combinational outputs are forced low while reset is asserted.
  always_comb begin
    stall = STALL_NONE;
    if (!rst_n)           stall = STALL_NONE;
    else if (flush_req)   stall = STALL_NONE;
    else if (dmem_busy)   stall = STALL_MEM;
    else if (div_stall)   stall = STALL_EX;
    else if (stallreq_id) stall = STALL_ID;
    else if (stallreq_if) stall = STALL_IF;
  end

  always_comb begin
    flush    = rst_n && flush_req;
    new_pc   = flush ? flush_pc : 32'h0;
    div_done = rst_n && in_div && cnt_zero && !dmem_busy && !flush_req;
    div_busy = in_div;
    perf_stall_cnt = perf_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perf_d  = perf_q + {31'b0, stall[0]};
    if (!in_div) begin
      if (div_start && !flush_req && !dmem_busy) begin
        state_d = S_DIV;
        cnt_d   = CNT_LOAD;
      end
    end else begin
      if (flush_req) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (!dmem_busy) begin
        if (cnt_zero) state_d = S_IDLE;
        else          cnt_d   = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      perf_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_if, stallreq_id, div_start, dmem_busy, flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush, div_busy, div_done;
  logic [31:0] new_pc, perf_stall_cnt;

  int errors = 0;
  int checks = 0;
  logic saw_done;

  localparam logic [5:0] S_MEM = 6'b011111;
  localparam logic [5:0] S_EX  = 6'b001111;
  localparam logic [5:0] S_ID  = 6'b000111;
  localparam logic [5:0] S_IF  = 6'b000011;

  pipe_ctrl #(.DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .div_start(div_start), .dmem_busy(dmem_busy),
    .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .div_busy(div_busy), .div_done(div_done),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_stall"}, {26'b0, stall}, 32'h0);
    chk({tag, "_flush"}, {31'b0, flush}, 32'h0);
    chk({tag, "_newpc"}, new_pc, 32'h0);
    chk({tag, "_busy"}, {31'b0, div_busy}, 32'h0);
    chk({tag, "_done"}, {31'b0, div_done}, 32'h0);
    chk({tag, "_perf"}, perf_stall_cnt, 32'h0);
  endtask

  initial begin
    // Reset with every request asserted: outputs must all be zero.
    rst_n = 1'b0;
    stallreq_if = 1'b1; stallreq_id = 1'b1; div_start = 1'b1;
    dmem_busy = 1'b1; flush_req = 1'b1; flush_pc = 32'hDEADBEEF;
    #3;
    all_zero("rst");
    cyc(); cyc();
    rst_n = 1'b1;
    stallreq_if = 1'b0; stallreq_id = 1'b0; div_start = 1'b0;
    dmem_busy = 1'b0; flush_req = 1'b0; flush_pc = 32'h0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_stall", {26'b0, stall}, 32'h0);
      chk("idle_busy", {31'b0, div_busy}, 32'h0);
      chk("idle_flush", {31'b0, flush}, 32'h0);
      cyc();
    end
    @(negedge clk);
    chk("idle_perf", perf_stall_cnt, 32'd0);
    cyc();

    // Single-cycle ID stall, then IF stall, then ID over IF priority
    stallreq_id = 1'b1;
    @(negedge clk); chk("id_stall", {26'b0, stall}, {26'b0, S_ID});
    cyc();
    stallreq_id = 1'b0;
    @(negedge clk);
    chk("id_release", {26'b0, stall}, 32'h0);
    chk("id_perf", perf_stall_cnt, 32'd1);
    cyc();
    stallreq_if = 1'b1;
    @(negedge clk); chk("if_stall", {26'b0, stall}, {26'b0, S_IF});
    cyc();
    stallreq_id = 1'b1;
    @(negedge clk); chk("id_over_if", {26'b0, stall}, {26'b0, S_ID});
    cyc();
    stallreq_id = 1'b0; stallreq_if = 1'b0;
    @(negedge clk); chk("perf_3", perf_stall_cnt, 32'd3);
    cyc();

    // Nominal divide: 32 EX-stall cycles, done on the 33rd; ID request masked mid-way
    div_start = 1'b1;
    for (int k = 0; k < 32; k++) begin
      stallreq_id = (k >= 5 && k <= 10);
      @(negedge clk);
      chk("div_stall", {26'b0, stall}, {26'b0, S_EX});
      chk("div_nodone", {31'b0, div_done}, 32'h0);
      chk("div_busy", {31'b0, div_busy}, {31'b0, (k != 0)});
      cyc();
    end
    stallreq_id = 1'b0;
    @(negedge clk);
    chk("div_done", {31'b0, div_done}, 32'h1);
    chk("div_done_stall", {26'b0, stall}, 32'h0);
    chk("div_done_busy", {31'b0, div_busy}, 32'h1);
    cyc();
    div_start = 1'b0;
    @(negedge clk);
    chk("div_after_busy", {31'b0, div_busy}, 32'h0);
    chk("div_after_done", {31'b0, div_done}, 32'h0);
    chk("div_perf", perf_stall_cnt, 32'd35);
    cyc();

    // div_start with dmem_busy in IDLE: MEM wins, divide accepted when memory frees up,
    // then memory busy for 3 cycles at cnt=5 delays the done pulse by 3 cycles
    div_start = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mem_idle_stall", {26'b0, stall}, {26'b0, S_MEM});
      chk("mem_idle_busy", {31'b0, div_busy}, 32'h0);
      cyc();
    end
    for (int k = 0; k < 36; k++) begin
      dmem_busy = (k >= 27 && k <= 29);
      @(negedge clk);
      if (k == 35) begin
        chk("ext_done", {31'b0, div_done}, 32'h1);
        chk("ext_done_stall", {26'b0, stall}, 32'h0);
      end else begin
        chk("ext_nodone", {31'b0, div_done}, 32'h0);
        chk("ext_stall", {26'b0, stall}, {26'b0, (dmem_busy ? S_MEM : S_EX)});
      end
      cyc();
    end
    div_start = 1'b0; dmem_busy = 1'b0;
    @(negedge clk);
    chk("ext_perf", perf_stall_cnt, 32'd72);
    chk("ext_idle", {31'b0, div_busy}, 32'h0);
    cyc();

    // Flush mid-divide aborts with no done pulse
    div_start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("fl_div_stall", {26'b0, stall}, {26'b0, S_EX});
      cyc();
    end
    flush_req = 1'b1; flush_pc = 32'hBFC00380; div_start = 1'b0;
    @(negedge clk);
    chk("fl_flush", {31'b0, flush}, 32'h1);
    chk("fl_newpc", new_pc, 32'hBFC00380);
    chk("fl_stall", {26'b0, stall}, 32'h0);
    chk("fl_nodone", {31'b0, div_done}, 32'h0);
    chk("fl_busy_same", {31'b0, div_busy}, 32'h1);
    cyc();
    flush_req = 1'b0; flush_pc = 32'h00001234;
    @(negedge clk);
    chk("fl_busy_next", {31'b0, div_busy}, 32'h0);
    chk("fl_flush_off", {31'b0, flush}, 32'h0);
    chk("fl_newpc_off", new_pc, 32'h0);
    chk("fl_perf", perf_stall_cnt, 32'd82);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      @(negedge clk);
      if (div_done) saw_done = 1'b1;
    end
    chk("fl_never_done", {31'b0, saw_done}, 32'h0);
    cyc();

    // Flush in IDLE blocks a divide start
    flush_req = 1'b1; div_start = 1'b1; flush_pc = 32'h80000180;
    @(negedge clk);
    chk("fli_stall", {26'b0, stall}, 32'h0);
    chk("fli_newpc", new_pc, 32'h80000180);
    cyc();
    flush_req = 1'b0; div_start = 1'b0;
    @(negedge clk);
    chk("fli_busy", {31'b0, div_busy}, 32'h0);
    cyc();

    // Asynchronous reset mid-divide with IF request pending
    div_start = 1'b1; stallreq_if = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    @(negedge clk);
    chk("rd_busy_pre", {31'b0, div_busy}, 32'h1);
    flush_req = 1'b1; flush_pc = 32'hCAFEF00D;
    #1;
    rst_n = 1'b0;
    #1;
    all_zero("rd");
    cyc(); cyc();
    all_zero("rd_hold");
    rst_n = 1'b1;
    div_start = 1'b0; stallreq_if = 1'b0; flush_req = 1'b0; flush_pc = 32'h0;
    @(negedge clk);
    all_zero("rd_rel");
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
